// File: rtl/commu_slot_arb_pkg.sv
// Shared constants and state encoding for the commu slot scheduler/arbiter.
// State codes are 4 bits wide to line up with the commu main FSM encoding.
package commu_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_GUARD = 4'd1,
        S_ARB   = 4'd2,
        S_FIRE  = 4'd3,
        S_BUSY  = 4'd4,
        S_TOUT  = 4'd5
    } slot_state_e;

    localparam int MISS_W = 16;

    localparam int GUARD_CYC_DEF = 16;
    localparam int TOUT_CYC_DEF  = 100000;

    // Short variants keep simulation builds from spending 100k cycles per watchdog test
    localparam int GUARD_CYC_SIM = 4;
    localparam int TOUT_CYC_SIM  = 100;

endpackage

// File: rtl/commu_slot_arb_if.sv
// Slot-arbiter bus: slot/request/done inputs and grant/status outputs.
// The master side drives the stimulus; the slave side is the arbiter.
interface commu_slot_arb_if
    import commu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic              slot_begin;
    logic [N_REQ-1:0]  req;
    logic              done_tail;
    logic              slot_rdy;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              busy;
    logic              tout_err;
    logic [MISS_W-1:0] miss_cnt;

    modport master (
        output slot_begin, req, done_tail,
        input  slot_rdy, grant, grant_idx, busy, tout_err, miss_cnt
    );

    modport slave (
        input  slot_begin, req, done_tail,
        output slot_rdy, grant, grant_idx, busy, tout_err, miss_cnt
    );
endinterface

// File: rtl/commu_slot_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr_i,
// wrapping around, so the previous owner has the lowest priority.
module commu_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int               c;
    logic [IDX_W-1:0] cIdx;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        c        = 0;
        cIdx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = int'(rr_ptr_i) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            cIdx = IDX_W'(c);
            if (!valid_o && req_i[cIdx]) begin
                valid_o        = 1'b1;
                idx_o          = cIdx;
                onehot_o[cIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commu_slot_arb.sv
// Slot scheduler in front of the commu main FSM: guard delay, round-robin grant,
// slot_rdy launch pulse, grant hold until done_tail, and a watchdog abort.
module commu_slot_arb
    import commu_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int GUARD_CYC = GUARD_CYC_DEF,
    parameter int TOUT_CYC  = TOUT_CYC_DEF,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    commu_slot_arb_if.slave      bus
);

    slot_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  rrPtr_q;
    logic [N_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]  grantIdx_q;
    logic [MISS_W-1:0] missCnt_q;

    logic [N_REQ-1:0]  pickOnehot;
    logic [IDX_W-1:0]  pickIdx;
    logic              pickValid;

    commu_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rrPtr_q),
        .onehot_o (pickOnehot),
        .idx_o    (pickIdx),
        .valid_o  (pickValid)
    );

    // Reset pointer at N_REQ-1 so index 0 is the first source to win.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rrPtr_q    <= IDX_W'(N_REQ - 1);
            grant_q    <= '0;
            grantIdx_q <= '0;
            missCnt_q  <= '0;
        end else begin
            if (bus.slot_begin && (state_q != S_IDLE) && (missCnt_q != '1)) begin
                missCnt_q <= missCnt_q + MISS_W'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.slot_begin) begin
                        state_q <= S_GUARD;
                        cnt_q   <= '0;
                    end
                end
                S_GUARD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(GUARD_CYC - 1)) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (pickValid) begin
                        grant_q    <= pickOnehot;
                        grantIdx_q <= pickIdx;
                        state_q    <= S_FIRE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FIRE: begin
                    cnt_q   <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // done_tail takes priority over a watchdog expiring on the same edge
                    if (bus.done_tail) begin
                        grant_q    <= '0;
                        grantIdx_q <= '0;
                        rrPtr_q    <= grantIdx_q;
                        state_q    <= S_IDLE;
                    end else if (cnt_q == CNT_W'(TOUT_CYC - 1)) begin
                        state_q <= S_TOUT;
                    end
                end
                S_TOUT: begin
                    grant_q    <= '0;
                    grantIdx_q <= '0;
                    rrPtr_q    <= grantIdx_q;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.slot_rdy  = (state_q == S_FIRE);
    assign bus.tout_err  = (state_q == S_TOUT);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.grant     = grant_q;
    assign bus.grant_idx = grantIdx_q;
    assign bus.miss_cnt  = missCnt_q;

endmodule

// File: tb/tb_commu_slot_arb.sv
// Randomized self-checking bench for commu_slot_arb against a transaction-level
// model of slot timing, round-robin ownership and missed-slot counting.
module tb_commu_slot_arb;
    import commu_pkg::*;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int GUARD = 16;
    localparam int TOUT  = 100;

    logic clk_sys = 1'b0;
    logic rst;

    int passCount  = 0;
    int totalCount = 0;
    int modelPtr   = N_REQ - 1;
    int modelMiss  = 0;

    commu_slot_arb_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus ();

    commu_slot_arb #(
        .N_REQ     (N_REQ),
        .IDX_W     (IDX_W),
        .GUARD_CYC (GUARD),
        .TOUT_CYC  (TOUT),
        .CNT_W     (32)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Owner = first requester after the previous owner, wrapping; -1 when nobody asks
    function automatic int pickOwner(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic stepCycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic modelReset();
        modelPtr  = N_REQ - 1;
        modelMiss = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_slot_rdy"}, 32'(bus.slot_rdy), 0);
        checkOutput({tag, "_grant"}, 32'(bus.grant), 0);
        checkOutput({tag, "_grant_idx"}, 32'(bus.grant_idx), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_tout_err"}, 32'(bus.tout_err), 0);
        checkOutput({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 0);
    endtask

    task automatic doReset();
        bus.slot_begin = 1'b0;
        bus.req        = '0;
        bus.done_tail  = 1'b0;
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        modelReset();
    endtask

    // One slot: doneAfter=0 withholds done_tail, rstAt>0 resets mid-BUSY at that cycle
    task automatic applyStimulus(input logic [N_REQ-1:0] reqVal, input int doneAfter,
                                 input int nMiss, input int rstAt);
        int   owner;
        logic early;
        logic held;
        logic [N_REQ-1:0] expGrant;
        owner = pickOwner(reqVal, modelPtr);
        early = 1'b0;
        held  = 1'b1;
        expGrant = (owner >= 0) ? N_REQ'(1 << owner) : '0;

        checkOutput("idle_before_slot", 32'(bus.busy), 0);
        bus.req = reqVal;
        bus.slot_begin = 1'b1;
        stepCycle();
        bus.slot_begin = 1'b0;
        checkOutput("busy_in_guard", 32'(bus.busy), 1);
        for (int i = 1; i <= GUARD; i++) begin
            stepCycle();
            if (bus.slot_rdy) early = 1'b1;
        end
        checkOutput("no_early_slot_rdy", 32'(early), 0);
        stepCycle();

        if (owner < 0) begin
            checkOutput("skip_slot_rdy", 32'(bus.slot_rdy), 0);
            checkOutput("skip_grant", 32'(bus.grant), 0);
            checkOutput("skip_back_idle", 32'(bus.busy), 0);
            return;
        end

        checkOutput("slot_rdy_pulse", 32'(bus.slot_rdy), 1);
        checkOutput("grant_onehot", 32'(bus.grant), 32'(expGrant));
        checkOutput("grant_idx", 32'(bus.grant_idx), 32'(owner));
        bus.req = N_REQ'($urandom);
        stepCycle();
        checkOutput("slot_rdy_one_cycle", 32'(bus.slot_rdy), 0);

        for (int d = 1; d <= TOUT; d++) begin
            if (d == rstAt) begin
                rst = 1'b1;
                #1;
                checkAllZero("async_rst");
                stepCycle();
                rst = 1'b0;
                modelReset();
                return;
            end
            if (d == doneAfter) bus.done_tail = 1'b1;
            if (d >= 2 && d < 2 + nMiss) begin
                bus.slot_begin = 1'b1;
                if (modelMiss < 16'hFFFF) modelMiss++;
            end
            stepCycle();
            bus.done_tail  = 1'b0;
            bus.slot_begin = 1'b0;
            if (d == doneAfter) begin
                checkOutput("held_during_busy", 32'(held), 1);
                checkOutput("done_grant_clear", 32'(bus.grant), 0);
                checkOutput("done_idx_clear", 32'(bus.grant_idx), 0);
                checkOutput("done_idle", 32'(bus.busy), 0);
                checkOutput("done_no_tout", 32'(bus.tout_err), 0);
                checkOutput("miss_cnt", 32'(bus.miss_cnt), 32'(modelMiss));
                modelPtr = owner;
                return;
            end
            if (d < TOUT) begin
                if (bus.grant !== expGrant || bus.grant_idx !== IDX_W'(owner) ||
                    bus.tout_err !== 1'b0 || bus.busy !== 1'b1) held = 1'b0;
            end
        end

        checkOutput("held_during_busy", 32'(held), 1);
        checkOutput("tout_err_pulse", 32'(bus.tout_err), 1);
        stepCycle();
        checkOutput("tout_err_one_cycle", 32'(bus.tout_err), 0);
        checkOutput("tout_grant_clear", 32'(bus.grant), 0);
        checkOutput("tout_idle", 32'(bus.busy), 0);
        checkOutput("miss_cnt", 32'(bus.miss_cnt), 32'(modelMiss));
        modelPtr = owner;
    endtask

    task automatic idleGap();
        repeat ($urandom_range(0, 3)) begin
            bus.done_tail = 1'($urandom);
            stepCycle();
        end
        bus.done_tail = 1'b0;
    endtask

    initial begin
        logic [N_REQ-1:0] r;
        int dn;
        int nm;

        rst = 1'b1;
        bus.slot_begin = 1'b0;
        bus.req        = '0;
        bus.done_tail  = 1'b0;
        #2;
        checkAllZero("reset");
        stepCycle();
        stepCycle();
        rst = 1'b0;
        modelReset();

        applyStimulus(4'b0100, 50, 0, 0);

        doReset();
        repeat (5) begin
            applyStimulus(4'b1111, $urandom_range(5, 40), 0, 0);
            idleGap();
        end

        applyStimulus(4'b0000, 0, 0, 0);
        applyStimulus(4'b0001, 20, 0, 0);

        applyStimulus(4'b0110, 0, 0, 0);
        applyStimulus(4'b1111, 30, 0, 0);

        applyStimulus(4'b1111, 40, 3, 0);
        applyStimulus(4'b1111, TOUT, 0, 0);

        doReset();
        applyStimulus(4'b1000, 0, 0, 20);
        applyStimulus(4'b1000, 15, 0, 0);

        for (int n = 0; n < 30; n++) begin
            r  = ($urandom_range(0, 5) == 0) ? '0 : N_REQ'($urandom);
            dn = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TOUT));
            nm = $urandom_range(0, 3);
            if (dn != 0 && dn < 2 + nm) nm = 0;
            applyStimulus(r, dn, nm, 0);
            idleGap();
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/commu_slot_arb.md
Name: commu_slot_arb

Overview:
Slot scheduler and arbiter in front of the commu main FSM. It receives the slot_begin pulse and waits a guard interval. It then picks one of N_REQ data sources with round-robin arbitration, pulses slot_rdy to launch the head/push/tail sequence, and holds the grant until done_tail. A watchdog recovers the slot if done_tail never arrives.

Parameters:
N_REQ, 4, number of requesting sources (2..8)
IDX_W, 2, width of grant_idx, equal to clog2(N_REQ)
GUARD_CYC, 16, clk_sys cycles between slot_begin and arbitration (>=1)
TOUT_CYC, 100000, maximum clk_sys cycles in S_BUSY before abort (>=2)
CNT_W, 32, width of the internal guard/timeout counter

Ports:
clk_sys  in  1  system clock
rst  in  1  reset: one clock; reset is asynchronous and active-high
slot_begin  in  1  one-cycle pulse marking the start of a slot
req  in  N_REQ  level request per source
done_tail  in  1  one-cycle pulse: tail phase finished
slot_rdy  out  1  one-cycle pulse that launches the transmit sequence
grant  out  N_REQ  one-hot owner of the current slot, 0 when there is no owner
grant_idx  out  IDX_W  binary index of the owner, 0 when there is no owner
busy  out  1  high from S_GUARD through S_TOUT
tout_err  out  1  one-cycle pulse when the watchdog aborts a slot
miss_cnt  out  16  saturating count of slot_begin pulses dropped because the block was busy

Behaviour:
- Reset (rst=1, async): state S_IDLE, all outputs 0, counter 0, rr_ptr = N_REQ-1, so index 0 has highest priority first.
- States: S_IDLE, S_GUARD, S_ARB, S_FIRE, S_BUSY, S_TOUT.
- S_IDLE: slot_begin=1 -> S_GUARD, counter cleared. Otherwise stay.
- S_GUARD: counter increments each cycle. When counter==GUARD_CYC-1 -> S_ARB.
- S_ARB: req==0 -> S_IDLE. The slot is skipped, no slot_rdy, rr_ptr unchanged.
- S_ARB with req!=0: select the first set bit searching from rr_ptr+1 upward with wrap-around. Register grant/grant_idx. Go to S_FIRE.
- S_FIRE: slot_rdy=1 (state-decoded, exactly one cycle). Counter cleared. Go to S_BUSY.
- S_BUSY: counter increments.
  - done_tail=1 -> S_IDLE; grant/grant_idx cleared; rr_ptr <= grant_idx.
  - Else if counter==TOUT_CYC-1 -> S_TOUT.
  - done_tail and timeout in the same cycle: done_tail wins, no tout_err.
- S_TOUT: tout_err=1 for one cycle; grant cleared; rr_ptr <= grant_idx; -> S_IDLE.
- Latency: slot_begin sampled at cycle t gives slot_rdy high at t+GUARD_CYC+2. grant is valid from t+GUARD_CYC+2 until the cycle after done_tail.
- Grant is latched. A requester dropping req during S_FIRE/S_BUSY does not remove the grant. A new req never preempts the current owner.
- slot_begin in any state other than S_IDLE is ignored for sequencing. miss_cnt increments by 1 and saturates at 16'hFFFF.
- done_tail outside S_BUSY is ignored.
- rst asserted mid-slot returns the block to reset values immediately. It does not generate tout_err.
- busy = (state != S_IDLE).

Decomposition:
- Package commu_pkg: state encodings (4-bit, same style as the commu main FSM), the 16-bit miss_cnt width, the default GUARD_CYC and TOUT_CYC constants, and shorter SIM-build variants of both.
- Sub-module commu_rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs a one-hot result, a binary index and a valid flag. It is instantiated once inside commu_slot_arb.

Test Plan:
- Reset then a single slot_begin with req=4'b0100, GUARD_CYC=16 -> slot_rdy pulses 18 cycles later; grant=4'b0100, grant_idx=2; done_tail 50 cycles later -> grant=0 next cycle, busy=0.
- req=4'b1111 held constant over 5 consecutive slots, each closed by done_tail -> grant_idx sequence 0,1,2,3,0.
- slot_begin with req=0 at arbitration time -> no slot_rdy pulse, grant stays 0, back to S_IDLE after 17 cycles; next slot with req=4'b0001 is granted index 0.
- Granted slot, done_tail withheld, TOUT_CYC=100 -> tout_err pulses once, 100 cycles after slot_rdy+1; grant cleared; next slot with req=4'b1111 grants the index after the aborted owner.
- Three slot_begin pulses while in S_BUSY -> miss_cnt=3, state and grant unaffected; done_tail and timeout in the same cycle -> no tout_err.
- rst asserted during S_BUSY with grant=4'b1000 -> all outputs 0 asynchronously; after release, req=4'b1000 is granted again (rr_ptr reset to 3).
